example_sdiv_seq_21s7s: RTL

EXAMPLE_SDIV_SEQ_21S7S -- requirements
Module: example_sdiv_seq_21s7s

---
 rtl/example_sdiv_pkg.sv | 27 ++
 rtl/example_sdiv_step.sv | 23 ++
 rtl/example_sdiv_seq_21s7s.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/example_sdiv_pkg.sv
// Shared constants and FSM state type for the sequential signed divider
// (21-bit dividend, 7-bit divisor, 14-bit quotient).
package example_sdiv_pkg;

    localparam int DIN0_W = 21;              // dividend width
    localparam int DIN1_W = 7;               // divisor / remainder width
    localparam int DOUT_W = 14;              // quotient output width
    localparam int QS_W   = DIN0_W + 1;      // signed full-range quotient width

    // Representable range of the 14-bit signed quotient.
    localparam int SAT_MAX = 8191;
    localparam int SAT_MIN = -8192;
    localparam logic [DOUT_W-1:0] DOUT_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0] DOUT_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

    // One restoring step per dividend bit.
    localparam int N_ITER = DIN0_W;
    localparam int CNT_W  = $clog2(N_ITER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/example_sdiv_step.sv
// One unsigned restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module example_sdiv_step
    import example_sdiv_pkg::*;
(
    input  logic [DIN1_W-1:0] rem_in,
    input  logic              dividend_bit,
    input  logic [DIN1_W-1:0] divisor,
    output logic [DIN1_W-1:0] rem_out,
    output logic              quot_bit
);

    logic [DIN1_W:0] shifted;
    logic [DIN1_W:0] diff;

    // The partial remainder stays below the divisor, so the shifted value
    // fits in DIN1_W+1 bits and the top bit of the difference is its sign.
    assign shifted  = {rem_in, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign quot_bit = ~diff[DIN1_W];
    assign rem_out  = quot_bit ? diff[DIN1_W-1:0] : shifted[DIN1_W-1:0];

endmodule

// File: rtl/example_sdiv_seq_21s7s.sv
// Sequential signed divider, 21-bit dividend by 7-bit divisor, fixed
// 23-cycle latency from accepted start to ap_done.
// Build option: define EXAMPLE_SDIV_SAT_EN to saturate an out-of-range
// quotient to 8191/-8192; otherwise dout is the low 14 bits (wrap).
module example_sdiv_seq_21s7s
    import example_sdiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 21,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 14
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf
);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [DIN0_W-1:0]   quo;        // dividend magnitude shifting out, quotient shifting in
    logic [DIN1_W-1:0]   prem;       // partial remainder magnitude
    logic [DIN1_W-1:0]   dvsr;       // divisor magnitude
    logic                dvd_neg;
    logic                dvs_neg;
    logic                dvs_zero;

    logic [DIN1_W-1:0]   step_rem;
    logic                step_q;

    logic signed [QS_W-1:0] q_signed;
    logic                   q_ovf;
    logic [DOUT_W-1:0]      fix_dout;
    logic [DIN1_W-1:0]      fix_rem;
    logic                   fix_ovf;

    example_sdiv_step u_step (
        .rem_in       (prem),
        .dividend_bit (quo[DIN0_W-1]),
        .divisor      (dvsr),
        .rem_out      (step_rem),
        .quot_bit     (step_q)
    );

    // State register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (ap_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and Moore handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        ap_idle   = 1'b0;
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = RUN;
            end
            RUN:  if (cnt == CNT_W'(N_ITER - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                ap_ready  = 1'b1;
                ap_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sign fix-up, range check and divide-by-zero override of the raw result.
    always_comb begin
        q_signed = {1'b0, quo};
        if (dvd_neg ^ dvs_neg) q_signed = -q_signed;
        q_ovf    = (q_signed > QS_W'(SAT_MAX)) || (q_signed < QS_W'(SAT_MIN));
        fix_dout = q_signed[DOUT_W-1:0];
`ifdef EXAMPLE_SDIV_SAT_EN
        if (q_ovf) fix_dout = q_signed[QS_W-1] ? DOUT_MIN : DOUT_MAX;
`endif
        fix_rem  = dvd_neg ? -prem : prem;
        fix_ovf  = q_ovf;
        if (dvs_zero) begin
            fix_dout = dvd_neg ? DOUT_MIN : DOUT_MAX;
            fix_rem  = '0;
            fix_ovf  = 1'b1;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt      <= '0;
            quo      <= '0;
            prem     <= '0;
            dvsr     <= '0;
            dvd_neg  <= 1'b0;
            dvs_neg  <= 1'b0;
            dvs_zero <= 1'b0;
            dout     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ap_start) begin
                    quo      <= din0[DIN0_W-1] ? -din0 : din0;
                    dvsr     <= din1[DIN1_W-1] ? -din1 : din1;
                    prem     <= '0;
                    dvd_neg  <= din0[DIN0_W-1];
                    dvs_neg  <= din1[DIN1_W-1];
                    dvs_zero <= (din1 == '0);
                    cnt      <= '0;
                end
                RUN: begin
                    quo  <= {quo[DIN0_W-2:0], step_q};
                    prem <= step_rem;
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    dout <= fix_dout;
                    rem  <= fix_rem;
                    ovf  <= fix_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule
